pc_fetch_unit: RTL and testbench

- Program-counter, instruction-register and memory-data-register stage of the multicycle MIPS datapath.
- Sits directly upstream of the main control FSM:
  - Produces the Opcode and Funct fields it decodes.
  - Consumes its PCWrite, Branch, PCSrc, IorD, IRWrite and MemWrite strobes.
- Selects the unified memory address, routes it to the text ROM or data RAM, and flags illegal accesses.

---
 rtl/pc_fetch_unit.sv | 92 +++++++++
 tb/tb_pc_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC, instruction register and memory data register of a multicycle MIPS datapath,
// with unified-address decode onto a text ROM and a data RAM plus a sticky illegal-access flag.
module pc_fetch_unit #(
    parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
    parameter logic [31:0] DATA_BASE = 32'h1001_0000,
    parameter int          ROM_AW    = 8,
    parameter int          RAM_AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              Branch,
    input  logic              Zero,
    input  logic              PCSrc,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       ALUOut,
    input  logic [31:0]       B,
    input  logic [31:0]       rom_rdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       PC,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    output logic [31:0]       Instr,
    output logic [5:0]        Opcode,
    output logic [5:0]        Funct,
    output logic [31:0]       Data,
    output logic              addr_fault,
    output logic [31:0]       instr_count
);
    logic [31:0] pc_q, pc_d, instr_q, instr_d, data_q, data_d, count_q, count_d;
    logic        fault_q, fault_d;
    logic [31:0] adr, rdata, next_pc;
    logic [29:0] rom_w, ram_w;
    logic        rom_hit, ram_hit, misaligned, taken, pc_en;

    always_comb begin
        adr        = IorD ? ALUOut : pc_q;
        // Word offsets from each base; a region hit means no bits above the region's word index.
        rom_w      = adr[31:2] - TEXT_BASE[31:2];
        ram_w      = adr[31:2] - DATA_BASE[31:2];
        rom_hit    = adr >= TEXT_BASE && rom_w[29:ROM_AW] == '0;
        ram_hit    = adr >= DATA_BASE && ram_w[29:RAM_AW] == '0;
        misaligned = |adr[1:0];
        rdata      = rom_hit ? rom_rdata : ram_hit ? ram_rdata : 32'h0;
        taken      = 1'b0;
        if (Branch == 1'b1 && Zero == 1'b1)
            taken = 1'b1;
        pc_en      = PCWrite | taken;
        next_pc    = PCSrc ? ALUOut : ALUResult;
        pc_d       = pc_en ? {next_pc[31:2], 2'b00} : pc_q;
        instr_d    = IRWrite ? rdata : instr_q;
        data_d     = rdata;
        count_d    = count_q + {31'b0, IRWrite};
        fault_d    = fault_q
                   | (IRWrite & (~rom_hit | misaligned))
                   | (MemWrite & (~ram_hit | misaligned))
                   | (pc_en & |next_pc[1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= TEXT_BASE;
            instr_q <= 32'h0;
            data_q  <= 32'h0;
            count_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    assign PC          = pc_q;
    assign rom_addr    = rom_w[ROM_AW-1:0];
    assign ram_addr    = ram_w[RAM_AW-1:0];
    assign ram_we      = MemWrite & ram_hit & ~misaligned & ~rst;
    assign ram_wdata   = B;
    assign Instr       = instr_q;
    assign Opcode      = instr_q[31:26];
    assign Funct       = instr_q[5:0];
    assign Data        = data_q;
    assign addr_fault  = fault_q;
    assign instr_count = count_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors for pc_fetch_unit, checked each cycle against an address-map model
// and pinned by hand-computed literal expectations.
module tb_pc_fetch_unit;
    localparam logic [31:0] TBASE = 32'h0040_0000;
    localparam logic [31:0] DBASE = 32'h1001_0000;

    logic        clk = 1'b0, rst = 1'b0;
    logic        PCWrite, Branch, Zero, PCSrc, IorD, IRWrite, MemWrite;
    logic [31:0] ALUResult, ALUOut, B, rom_rdata, ram_rdata;
    logic [31:0] PC, Instr, Data, instr_count, ram_wdata;
    logic [7:0]  rom_addr, ram_addr;
    logic        ram_we, addr_fault;
    logic [5:0]  Opcode, Funct;

    int n_vec = 0, n_err = 0;

    logic [31:0] m_pc = TBASE, m_instr = 32'h0, m_data = 32'h0, m_fetch = 32'h0, cnt_base = 32'h0;
    logic        m_fault = 1'b0;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .Branch(Branch), .Zero(Zero), .PCSrc(PCSrc),
        .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .ALUResult(ALUResult), .ALUOut(ALUOut),
        .B(B), .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .PC(PC), .rom_addr(rom_addr),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .Instr(Instr), .Opcode(Opcode),
        .Funct(Funct), .Data(Data), .addr_fault(addr_fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // A 256-word region starting at base covers 1024 bytes.
    function automatic bit hit(input logic [31:0] a, input logic [31:0] base);
        return a >= base && (a - base) < 32'd1024;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return hit(a, TBASE) ? rom_rdata : hit(a, DBASE) ? ram_rdata : 32'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [31:0] a, nx;
        bit en;
        if (rst) begin
            m_pc    <= TBASE;
            m_instr <= 32'h0;
            m_data  <= 32'h0;
            m_fetch <= 32'h0;
            m_fault <= 1'b0;
        end else begin
            a  = IorD ? ALUOut : m_pc;
            nx = PCSrc ? ALUOut : ALUResult;
            en = PCWrite;
            if (Branch == 1'b1 && Zero == 1'b1) en = 1'b1;
            if (en) m_pc <= nx & ~32'd3;
            if (IRWrite) begin
                m_instr <= rd(a);
                m_fetch <= m_fetch + 32'd1;
            end
            m_data <= rd(a);
            if ((IRWrite && (!hit(a, TBASE) || a % 4 != 0)) ||
                (MemWrite && (!hit(a, DBASE) || a % 4 != 0)) ||
                (en && nx % 4 != 0))
                m_fault <= 1'b1;
        end
    end

    always @(posedge clk) begin
        logic [31:0] a;
        #1;
        if (!rst) begin
            a = IorD ? ALUOut : m_pc;
            chk("PC", PC, m_pc);
            chk("Instr", Instr, m_instr);
            chk("Opcode", 32'(Opcode), 32'(m_instr[31:26]));
            chk("Funct", 32'(Funct), 32'(m_instr[5:0]));
            chk("Data", Data, m_data);
            chk("addr_fault", 32'(addr_fault), 32'(m_fault));
            chk("instr_count", instr_count, m_fetch + cnt_base);
            chk("ram_we", 32'(ram_we), 32'(MemWrite && hit(a, DBASE) && a % 4 == 0));
            chk("ram_wdata", ram_wdata, B);
            if (hit(a, TBASE)) chk("rom_addr", 32'(rom_addr), (a - TBASE) / 4);
            if (hit(a, DBASE)) chk("ram_addr", 32'(ram_addr), (a - DBASE) / 4);
        end
    end

    task automatic idle();
        PCWrite = 0; Branch = 0; Zero = 0; PCSrc = 0; IorD = 0; IRWrite = 0; MemWrite = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        ALUResult = 0; ALUOut = 0; B = 0; rom_rdata = 0; ram_rdata = 0;
        #1 rst = 1'b1;
        #1;
        chk("rst PC", PC, 32'h0040_0000);
        chk("rst Instr", Instr, 32'h0);
        chk("rst Data", Data, 32'h0);
        chk("rst fault", 32'(addr_fault), 32'h0);
        chk("rst count", instr_count, 32'h0);
        chk("rst ram_we", 32'(ram_we), 32'h0);
        #1 rst = 1'b0;

        PCWrite = 1; IRWrite = 1; ALUResult = 32'h0040_0004; rom_rdata = 32'h2008_0005;
        cyc(); idle();
        chk("fetch PC", PC, 32'h0040_0004);
        chk("fetch Instr", Instr, 32'h2008_0005);
        chk("fetch Opcode", 32'(Opcode), 32'h08);
        chk("fetch Funct", 32'(Funct), 32'h05);
        chk("fetch count", instr_count, 32'h1);

        Branch = 1; Zero = 1; PCSrc = 1; ALUOut = 32'h0040_0020;
        cyc();
        chk("beq taken PC", PC, 32'h0040_0020);
        Zero = 0; ALUOut = 32'h0040_0040;
        cyc();
        chk("beq nz PC", PC, 32'h0040_0020);
        Branch = 1'bx; Zero = 1;
        cyc();
        if (Branch !== 1'b1) chk("beq x PC", PC, 32'h0040_0020);
        idle();

        MemWrite = 1; IorD = 1; ALUOut = 32'h1001_0008; B = 32'hDEAD_BEEF; ram_rdata = 32'h1111_2222;
        #1;
        chk("sw ram_we", 32'(ram_we), 32'h1);
        chk("sw ram_addr", 32'(ram_addr), 32'h2);
        chk("sw ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        cyc();
        chk("sw fault", 32'(addr_fault), 32'h0);
        chk("sw Data", Data, 32'h1111_2222);

        ALUOut = 32'h0040_0000;
        #1;
        chk("sw rom ram_we", 32'(ram_we), 32'h0);
        cyc(); idle();
        chk("sw rom fault", 32'(addr_fault), 32'h1);
        repeat (10) cyc();
        chk("fault sticky", 32'(addr_fault), 32'h1);

        #1 rst = 1'b1; cnt_base = 32'h0;
        #1;
        chk("rst2 fault", 32'(addr_fault), 32'h0);
        chk("rst2 PC", PC, 32'h0040_0000);
        rst = 1'b0;

        PCWrite = 1; ALUResult = 32'h1234_0000;
        cyc(); idle();
        chk("jump unmapped PC", PC, 32'h1234_0000);
        chk("jump unmapped fault", 32'(addr_fault), 32'h0);
        IRWrite = 1; rom_rdata = 32'hAAAA_5555; ram_rdata = 32'h5555_AAAA;
        cyc(); idle();
        chk("fetch unmapped Instr", Instr, 32'h0);
        chk("fetch unmapped fault", 32'(addr_fault), 32'h1);

        force dut.count_q = 32'hFFFF_FFFE;
        cnt_base = 32'hFFFF_FFFE - m_fetch;
        #1 release dut.count_q;
        IRWrite = 1;
        cyc();
        chk("count max", instr_count, 32'hFFFF_FFFF);
        cyc(); idle();
        chk("count wrap", instr_count, 32'h0);

        #1 rst = 1'b1; cnt_base = 32'h0;
        #1 rst = 1'b0;
        PCWrite = 1; ALUResult = 32'h0040_0013;
        cyc(); idle();
        chk("misaligned PC", PC, 32'h0040_0010);
        chk("misaligned fault", 32'(addr_fault), 32'h1);

        PCWrite = 1; IRWrite = 1; ALUResult = 32'h0040_0018; rom_rdata = 32'h0000_0020;
        cyc(); idle();
        #1 rst = 1'b1; cnt_base = 32'h0;
        #1;
        chk("async rst PC", PC, 32'h0040_0000);
        chk("async rst count", instr_count, 32'h0);
        chk("async rst Instr", Instr, 32'h0);
        chk("async rst fault", 32'(addr_fault), 32'h0);
        #3 rst = 1'b0;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
